// File: rtl/wb_mprj_chan_bridge.sv
// wb_mprj_chan_bridge
//   Wishbone slave for the user project area. Splits a 2^(WIN_BITS+CHW) byte
//   region at ADDR_BASE into NCH channel windows, one CSR window and the
//   unmapped remainder. Channel accesses run a registered req/ack handshake
//   with a per-access timeout. The CSR window holds the sticky timeout flags
//   and the interrupt enables.
//
// Ports
//   wb_clk_i, wb_rst_ni           clock, synchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i  Wishbone request
//   wbs_ack_o, wbs_dat_o          one-cycle ack, read data (0 when no ack)
//   ch_req_o                      one-hot channel request
//   ch_we/sel/adr/wdat_o          latched access attributes
//   ch_ack_i, ch_rdat_i           per-channel ack and read data (32 bits each)
//   irq_o                         registered |(to_flag & irq_en)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for cyc & stb inside the region
// S_REQ  | channel request outstanding, timeout counter running
// S_RESP | wbs_ack_o high for this single cycle

module wb_mprj_chan_bridge #(
  parameter int unsigned NCH       = 4,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int unsigned WIN_BITS  = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [NCH-1:0]      ch_req_o,
  output logic                ch_we_o,
  output logic [3:0]          ch_sel_o,
  output logic [WIN_BITS-1:0] ch_adr_o,
  output logic [31:0]         ch_wdat_o,
  input  logic [NCH-1:0]      ch_ack_i,
  input  logic [NCH*32-1:0]   ch_rdat_i,
  output logic                irq_o
);

  localparam int unsigned CHW      = $clog2(NCH + 1);
  localparam int unsigned RGN_BITS = WIN_BITS + CHW;
  localparam int unsigned CNTW     = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [CHW-1:0]  IDX_CSR  = CHW'(NCH);
  localparam logic [31:0]     ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [CHW-1:0]      idx_q, idx_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [WIN_BITS-1:0] adr_q, adr_d;
  logic [31:0]         wdat_q, wdat_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NCH-1:0]      to_flag_q, to_flag_d;
  logic [NCH-1:0]      irq_en_q, irq_en_d;
  logic                irq_q;

  logic           hit, is_ch, is_csr, accept;
  logic [CHW-1:0] idx;
  logic [NCH-1:0] sel_onehot;
  logic           ack_sel;
  logic [31:0]    rdat_sel;
  logic [31:0]    csr_rdata;

  assign hit    = (wbs_adr_i[31:RGN_BITS] == ADDR_BASE[31:RGN_BITS]);
  assign idx    = wbs_adr_i[WIN_BITS +: CHW];
  assign is_ch  = (idx < IDX_CSR);
  assign is_csr = (idx == IDX_CSR);
  assign accept = (state_q == S_IDLE) && wbs_cyc_i && wbs_stb_i && hit;

  // Compare-based select rather than indexing by idx_q, so only the latched
  // channel's ack/data is ever observed regardless of NCH.
  always_comb begin
    sel_onehot = '0;
    ack_sel    = 1'b0;
    rdat_sel   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == CHW'(k)) begin
        sel_onehot[k] = 1'b1;
        ack_sel       = ch_ack_i[k];
        rdat_sel      = ch_rdat_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (wbs_adr_i[3:2])
      2'd0:    csr_rdata[NCH-1:0] = to_flag_q;
      2'd1:    csr_rdata[NCH-1:0] = irq_en_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    rdata_d   = rdata_q;
    to_flag_d = to_flag_q;
    irq_en_d  = irq_en_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d  = idx;
          we_d   = wbs_we_i;
          sel_d  = wbs_sel_i;
          adr_d  = wbs_adr_i[WIN_BITS-1:0];
          wdat_d = wbs_dat_i;
          if (is_ch) begin
            state_d = S_REQ;
            cnt_d   = '0;
          end else begin
            state_d = S_RESP;
            if (is_csr) begin
              rdata_d = wbs_we_i ? 32'h0 : csr_rdata;
              if (wbs_we_i && wbs_sel_i[0]) begin
                case (wbs_adr_i[3:2])
                  2'd0:    to_flag_d = to_flag_q & ~wbs_dat_i[NCH-1:0];
                  2'd1:    irq_en_d  = wbs_dat_i[NCH-1:0];
                  default: ;
                endcase
              end
            end else begin
              rdata_d = wbs_we_i ? 32'h0 : ERR_DATA;
            end
          end
        end
      end
      S_REQ: begin
        // Master abandoning the cycle takes priority over everything else.
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else if (ack_sel) begin
          state_d = S_RESP;
          rdata_d = rdat_sel;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RESP;
          rdata_d   = ERR_DATA;
          to_flag_d = to_flag_q | sel_onehot;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      rdata_q   <= '0;
      to_flag_q <= '0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      rdata_q   <= rdata_d;
      to_flag_q <= to_flag_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= |(to_flag_q & irq_en_q);
    end
  end

  assign wbs_ack_o = (state_q == S_RESP);
  assign wbs_dat_o = wbs_ack_o ? rdata_q : 32'h0;
  assign ch_req_o  = (state_q == S_REQ) ? sel_onehot : '0;
  assign ch_we_o   = we_q;
  assign ch_sel_o  = sel_q;
  assign ch_adr_o  = adr_q;
  assign ch_wdat_o = wdat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_mprj_chan_bridge.sv
// tb_wb_mprj_chan_bridge
//   Directed vector bench for wb_mprj_chan_bridge with NCH=4, WIN_BITS=16,
//   TIMEOUT=4. Channel k sits at 0x3000_0000 + k*0x1_0000, CSR at +0x4_0000.

module tb_wb_mprj_chan_bridge;

  localparam logic [31:0] B   = 32'h3000_0000;
  localparam logic [31:0] CSR = 32'h3004_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, dat_i;
  logic         ack;
  logic [31:0]  dat_o;
  logic [3:0]   ch_req;
  logic         ch_we;
  logic [3:0]   ch_sel;
  logic [15:0]  ch_adr;
  logic [31:0]  ch_wdat;
  logic [3:0]   ch_ack;
  logic [127:0] ch_rdat;
  logic         irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_mprj_chan_bridge #(
    .NCH(4), .ADDR_BASE(32'h3000_0000), .WIN_BITS(16), .TIMEOUT(4)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .ch_req_o(ch_req), .ch_we_o(ch_we), .ch_sel_o(ch_sel), .ch_adr_o(ch_adr),
    .ch_wdat_o(ch_wdat), .ch_ack_i(ch_ack), .ch_rdat_i(ch_rdat), .irq_o(irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          ack_at;    // REQ cycle in which ch_ack_i is raised, 0 = never
    logic [3:0]  ack_bits;
    logic [3:0]  noise;     // driven on every other REQ cycle
    logic [31:0] rdat;
    int          exp_lat;   // cycles from the accepting edge to ack
    logic [3:0]  exp_req;
    int          exp_nreq;
    logic        chk_dat;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vt[23];

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] wd, input int aat, input logic [3:0] ab,
                              input logic [3:0] nz, input logic [31:0] rd, input int lat,
                              input logic [3:0] rq, input int nrq, input logic cd,
                              input logic [31:0] ed);
    vec_t v;
    v.we = w; v.adr = a; v.sel = s; v.wdat = wd; v.ack_at = aat; v.ack_bits = ab;
    v.noise = nz; v.rdat = rd; v.exp_lat = lat; v.exp_req = rq; v.exp_nreq = nrq;
    v.chk_dat = cd; v.exp_dat = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          lat, nreq, ci;
    logic [31:0] rd;
    v = vt[i];
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = v.we; sel = v.sel; adr = v.adr; dat_i = v.wdat;
    for (int k = 0; k < 4; k++) ch_rdat[32*k +: 32] = 32'hBAD0_0000 | 32'(k);
    ci = int'(v.adr[18:16]);
    if (ci < 4) ch_rdat[32*ci +: 32] = v.rdat;
    lat = 0; nreq = 0; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = c;
        rd  = dat_o;
        break;
      end
      if (ch_req != 4'b0) nreq += (ch_req == v.exp_req) ? 1 : 100;
      ch_ack = (c == v.ack_at) ? v.ack_bits : v.noise;
    end
    cyc = 1'b0; stb = 1'b0; ch_ack = 4'b0;
    chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d req_cycles", i), 32'(nreq), 32'(v.exp_nreq));
    if (v.chk_dat) chk($sformatf("v%0d rdata", i), rd, v.exp_dat);
    if (v.exp_req != 4'b0) begin
      chk($sformatf("v%0d ch_adr", i), 32'(ch_adr), 32'(v.adr[15:0]));
      chk($sformatf("v%0d ch_we", i), 32'(ch_we), 32'(v.we));
      if (v.we) begin
        chk($sformatf("v%0d ch_sel", i), 32'(ch_sel), 32'(v.sel));
        chk($sformatf("v%0d ch_wdat", i), ch_wdat, v.wdat);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic outside(input logic [31:0] a);
    int bad;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = a;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ack || ch_req != 4'b0) bad++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk($sformatf("outside %08h activity", a), 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(0, B+32'h1_0010, 4'hF, 0, 3, 4'b0010, 0, 32'h1234_5678, 4, 4'b0010, 3, 1, 32'h1234_5678);
    vt[1]  = mk(1, B+32'h0_0124, 4'b0110, 32'hA5A5_1234, 1, 4'b0001, 0, 0, 2, 4'b0001, 1, 0, 0);
    vt[2]  = mk(0, B+32'h3_0000, 4'hF, 0, 0, 0, 0, 32'h1111_1111, 5, 4'b1000, 4, 1, 32'hDEAD_BEEF);
    vt[3]  = mk(0, CSR, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h8);
    vt[4]  = mk(1, CSR+32'h4, 4'b1110, 32'hF, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vt[5]  = mk(0, CSR+32'h4, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
    vt[6]  = mk(1, CSR+32'h4, 4'b0001, 32'h8, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vt[7]  = mk(0, CSR+32'h4, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h8);
    vt[8]  = mk(1, CSR, 4'b0001, 32'h8, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vt[9]  = mk(0, CSR, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
    vt[10] = mk(0, B+32'h2_0040, 4'hF, 0, 4, 4'b0100, 0, 32'hCAFE_F00D, 5, 4'b0100, 4, 1, 32'hCAFE_F00D);
    vt[11] = mk(0, CSR, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
    vt[12] = mk(0, B+32'h0_0008, 4'hF, 0, 2, 4'b0001, 4'b0100, 32'h0BAD_CAFE, 3, 4'b0001, 2, 1, 32'h0BAD_CAFE);
    vt[13] = mk(1, CSR+32'h8, 4'hF, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vt[14] = mk(0, CSR+32'h8, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
    vt[15] = mk(0, CSR+32'hC, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
    vt[16] = mk(0, B+32'h5_0000, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hDEAD_BEEF);
    vt[17] = mk(1, B+32'h7_FFFC, 4'hF, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vt[18] = mk(0, CSR+32'h4, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h8);
    vt[19] = mk(1, B+32'h3_FFFC, 4'b1001, 32'h1357_9BDF, 2, 4'b1000, 0, 0, 3, 4'b1000, 2, 0, 0);
    vt[20] = mk(0, B+32'h3_0004, 4'hF, 0, 0, 0, 0, 0, 5, 4'b1000, 4, 1, 32'hDEAD_BEEF);
    vt[21] = mk(0, CSR, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
    vt[22] = mk(0, CSR+32'h4, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; dat_i = '0; ch_ack = 4'h0; ch_rdat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset dat", dat_o, 32'd0);
    chk("reset req", 32'(ch_req), 32'd0);
    chk("reset ch_attr", {ch_wdat[15:0] | ch_adr, 11'd0, ch_we, ch_sel}, 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i <= 5; i++) run_vec(i);
    chk("irq disabled", 32'(irq), 32'd0);
    for (int i = 6; i <= 7; i++) run_vec(i);
    chk("irq enabled", 32'(irq), 32'd1);
    run_vec(8);
    chk("irq after w1c", 32'(irq), 32'd0);
    for (int i = 9; i <= 19; i++) run_vec(i);
    run_vec(20);
    chk("irq before reset", 32'(irq), 32'd1);

    // reset in the middle of a channel write
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = B + 32'h2_0020; dat_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    chk("pre-reset req", 32'(ch_req), 32'b0100);
    chk("pre-reset wdat", ch_wdat, 32'h5555_AAAA);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid-reset req", 32'(ch_req), 32'd0);
    chk("mid-reset ack", 32'(ack), 32'd0);
    chk("mid-reset attr", {ch_wdat[15:0] | ch_adr, 11'd0, ch_we, ch_sel}, 32'd0);
    chk("mid-reset irq", 32'(irq), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(21);
    run_vec(22);

    // abort: drop cyc after two REQ cycles
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = B + 32'h1_0000;
    @(posedge clk); #1;
    chk("abort req", 32'(ch_req), 32'b0010);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("abort req drop", 32'(ch_req), 32'd0);
    begin
      int acks = 32'(ack);
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        if (ack) acks++;
      end
      chk("abort no ack", 32'(acks), 32'd0);
    end
    run_vec(21);

    outside(32'h2FFF_FFF0);
    outside(32'h3008_0000);
    run_vec(22);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
